// File: rtl/mean_arb_if.sv
// Bundle of requester, engine and result signals around the mean_arb scheduler.
// master: the scheduler side. slave: the requesters/engine environment.
interface mean_arb_if #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CH_BITS  = 2,
    parameter int unsigned bit_wide = 8
);
    logic [NUM_CH-1:0]          req;
    logic [NUM_CH*bit_wide-1:0] req_data;
    logic [NUM_CH-1:0]          ack;
    logic                       eng_valid;
    logic                       eng_ready;
    logic [CH_BITS-1:0]         eng_ch;
    logic [bit_wide-1:0]        eng_data;
    logic                       eng_res_valid;
    logic [bit_wide-1:0]        eng_res;
    logic                       res_valid;
    logic [CH_BITS-1:0]         res_ch;
    logic [bit_wide-1:0]        res_data;
    logic                       res_warm;
    logic                       busy;
    logic                       err;

    modport master (
        input  req, req_data, eng_ready, eng_res_valid, eng_res,
        output ack, eng_valid, eng_ch, eng_data, res_valid, res_ch, res_data, res_warm, busy,
               err
    );

    modport slave (
        output req, req_data, eng_ready, eng_res_valid, eng_res,
        input  ack, eng_valid, eng_ch, eng_data, res_valid, res_ch, res_data, res_warm, busy, err
    );
endinterface

// File: rtl/mean_arb.sv
// Round-robin scheduler sharing one moving-average engine among NUM_CH requesters.
// Optional WAIT timeout enabled by defining MEAN_ARB_TIMEOUT_EN.
module mean_arb #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CH_BITS  = 2,
    parameter int unsigned bit_wide = 8,
    parameter int unsigned buf_size = 16,
    parameter int unsigned cont_bit = 4,
    parameter int unsigned TIMEOUT  = 63
) (
    input logic        clk,
    input logic        rst,
    mean_arb_if.master bus
);
    localparam int unsigned FillW = cont_bit + 1;
    localparam logic [FillW-1:0] FillMax = FillW'(buf_size);
`ifdef MEAN_ARB_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT + 1);
    localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT - 1);
`endif

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e              state_q, state_d;
    logic [CH_BITS-1:0]  last_q, last_d;
    logic [CH_BITS-1:0]  gnt_q, gnt_d;
    logic [bit_wide-1:0] eng_data_q, eng_data_d;
    logic [FillW-1:0]    fill_q [NUM_CH];
    logic [FillW-1:0]    fill_d [NUM_CH];
    logic                res_valid_q, res_valid_d;
    logic [CH_BITS-1:0]  res_ch_q, res_ch_d;
    logic [bit_wide-1:0] res_data_q, res_data_d;
    logic                res_warm_q, res_warm_d;
    logic                err_q, err_d;
`ifdef MEAN_ARB_TIMEOUT_EN
    logic [ToW-1:0]      to_cnt_q, to_cnt_d;
    logic                inc_q, inc_d;  // fill really moved at handshake, so a timeout may undo it
`endif

    logic [NUM_CH-1:0]   ack;
    logic [bit_wide-1:0] samp [NUM_CH];
    logic                pick_found;
    logic [CH_BITS-1:0]  pick_ch;
    logic [CH_BITS-1:0]  pick_idx;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_samp
        assign samp[k] = bus.req_data[k*bit_wide +: bit_wide];
    end

    // First requester after the last served channel, wrapping modulo NUM_CH.
    always_comb begin
        pick_found = 1'b0;
        pick_ch    = '0;
        pick_idx   = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            pick_idx = CH_BITS'((32'(last_q) + i) % NUM_CH);
            if (!pick_found && bus.req[pick_idx]) begin
                pick_found = 1'b1;
                pick_ch    = pick_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        eng_data_d  = eng_data_q;
        fill_d      = fill_q;
        res_valid_d = 1'b0;
        res_ch_d    = res_ch_q;
        res_data_d  = res_data_q;
        res_warm_d  = res_warm_q;
        err_d       = 1'b0;
        ack         = '0;
`ifdef MEAN_ARB_TIMEOUT_EN
        inc_d       = inc_q;
        to_cnt_d    = (state_q == StWait) ? to_cnt_q + 1'b1 : '0;
`endif
        unique case (state_q)
            StIdle: begin
                err_d = bus.eng_res_valid;
                if (pick_found) begin
                    gnt_d      = pick_ch;
                    eng_data_d = samp[pick_ch];
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                err_d = bus.eng_res_valid;
                if (bus.eng_ready) begin
                    ack[gnt_q] = 1'b1;
                    last_d     = gnt_q;
                    if (fill_q[gnt_q] != FillMax) begin
                        fill_d[gnt_q] = fill_q[gnt_q] + 1'b1;
                    end
`ifdef MEAN_ARB_TIMEOUT_EN
                    inc_d = (fill_q[gnt_q] != FillMax);
`endif
                    state_d = StWait;
                end
            end
            StWait: begin
                if (bus.eng_res_valid) begin
                    res_valid_d = 1'b1;
                    res_ch_d    = gnt_q;
                    res_data_d  = bus.eng_res;
                    res_warm_d  = (fill_q[gnt_q] == FillMax);
                    state_d     = StIdle;
                end
`ifdef MEAN_ARB_TIMEOUT_EN
                else if (to_cnt_q == ToLast) begin
                    err_d = 1'b1;
                    if (inc_q) begin
                        fill_d[gnt_q] = fill_q[gnt_q] - 1'b1;
                    end
                    state_d = StIdle;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            last_q      <= CH_BITS'(NUM_CH - 1);
            gnt_q       <= '0;
            eng_data_q  <= '0;
            fill_q      <= '{default: '0};
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_data_q  <= '0;
            res_warm_q  <= 1'b0;
            err_q       <= 1'b0;
`ifdef MEAN_ARB_TIMEOUT_EN
            to_cnt_q    <= '0;
            inc_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            eng_data_q  <= eng_data_d;
            fill_q      <= fill_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
            res_data_q  <= res_data_d;
            res_warm_q  <= res_warm_d;
            err_q       <= err_d;
`ifdef MEAN_ARB_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            inc_q       <= inc_d;
`endif
        end
    end

    assign bus.ack       = ack;
    assign bus.eng_valid = (state_q == StIssue);
    assign bus.eng_ch    = gnt_q;
    assign bus.eng_data  = eng_data_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_ch    = res_ch_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_warm  = res_warm_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mean_arb.sv
// Directed plus randomized bench for mean_arb against a round-robin / fill-count reference model.
module tb_mean_arb;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: who was served last and how many samples each window holds.
    int         last_m;
    int         fill_m [4];
    logic [7:0] smp [4];

    mean_arb_if #(.NUM_CH(4), .CH_BITS(2), .bit_wide(8)) bus ();

    mean_arb #(
        .NUM_CH  (4),
        .CH_BITS (2),
        .bit_wide(8),
        .buf_size(16),
        .cont_bit(4),
        .TIMEOUT (63)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] m);
        for (int i = 1; i <= 4; i++) begin
            int c = (last_m + i) % 4;
            if (m[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        last_m = 3;
        for (int i = 0; i < 4; i++) fill_m[i] = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction starting from IDLE; returns with the DUT idle again.
    task automatic txn(input logic [3:0] mask, input int rdy_wait, input int res_lat,
                       input bit spur, input logic [7:0] res);
        int         ch;
        logic [7:0] d;
        ch = pick(mask);
        d  = smp[ch];
        bus.req      = mask;
        bus.req_data = {smp[3], smp[2], smp[1], smp[0]};
        tick();
        chk("busy_issue", bus.busy, 1);
        // The sample is captured at grant; later source changes must not leak through.
        bus.req_data = $urandom;
        if ($urandom_range(0, 1) == 1) bus.req = '0;
        for (int k = 0; k < rdy_wait; k++) begin
            chk("eng_valid_hold", bus.eng_valid, 1);
            chk("eng_ch_hold", bus.eng_ch, ch);
            chk("eng_data_hold", bus.eng_data, d);
            chk("ack_early", bus.ack, 0);
            bus.eng_res_valid = spur && (k == 0);
            tick();
            bus.eng_res_valid = 1'b0;
            if (spur && k == 0) chk("err_in_issue", bus.err, 1);
        end
        chk("eng_valid", bus.eng_valid, 1);
        chk("eng_ch", bus.eng_ch, ch);
        chk("eng_data", bus.eng_data, d);
        bus.eng_ready = 1'b1;
        #1;
        chk("ack", bus.ack, 32'(1) << ch);
        tick();
        bus.eng_ready = 1'b0;
        bus.req       = '0;
        last_m = ch;
        if (fill_m[ch] < 16) fill_m[ch]++;
        chk("eng_valid_wait", bus.eng_valid, 0);
        chk("ack_wait", bus.ack, 0);
        for (int k = 0; k < res_lat; k++) begin
            chk("res_valid_early", bus.res_valid, 0);
            chk("busy_wait", bus.busy, 1);
            tick();
        end
        bus.eng_res_valid = 1'b1;
        bus.eng_res       = res;
        tick();
        bus.eng_res_valid = 1'b0;
        chk("res_valid", bus.res_valid, 1);
        chk("res_ch", bus.res_ch, ch);
        chk("res_data", bus.res_data, res);
        chk("res_warm", bus.res_warm, (fill_m[ch] >= 16) ? 1 : 0);
        chk("busy_done", bus.busy, 0);
        chk("err_done", bus.err, 0);
        tick();
        chk("res_valid_pulse", bus.res_valid, 0);
    endtask

    initial begin
        rst               = 1'b1;
        bus.req           = '0;
        bus.req_data      = '0;
        bus.eng_ready     = 1'b0;
        bus.eng_res_valid = 1'b0;
        bus.eng_res       = '0;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_busy", bus.busy, 0);
        chk("rst_eng_valid", bus.eng_valid, 0);
        chk("rst_ack", bus.ack, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_eng_data", bus.eng_data, 0);
        chk("rst_res_warm", bus.res_warm, 0);

        // Single channel 0, sample and result 0x10.
        smp[0] = 8'h10;
        txn(4'b0001, 0, 1, 1'b0, 8'h10);

        // All channels requesting: strict rotation.
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 4; i++) smp[i] = 8'($urandom);
            txn(4'b1111, 0, 0, 1'b0, 8'($urandom));
        end

        // Channel 2 alone until its window warms and saturates.
        for (int n = 0; n < 20; n++) begin
            smp[2] = 8'($urandom);
            txn(4'b0100, $urandom_range(0, 1), $urandom_range(0, 2), 1'b0, 8'($urandom));
        end

`ifdef MEAN_ARB_TIMEOUT_EN
        // Lost result: timeout after 63 WAIT cycles, fill count restored.
        begin
            int ch;
            smp[2] = 8'h5a;
            bus.req      = 4'b0100;
            bus.req_data = {smp[3], smp[2], smp[1], smp[0]};
            ch = pick(4'b0100);
            tick();
            bus.eng_ready = 1'b1;
            tick();
            bus.eng_ready = 1'b0;
            bus.req       = '0;
            last_m = ch;
            for (int k = 0; k < 62; k++) begin
                chk("to_busy", bus.busy, 1);
                chk("to_err_early", bus.err, 0);
                tick();
            end
            tick();
            chk("to_err", bus.err, 1);
            chk("to_busy_idle", bus.busy, 0);
            chk("to_res_valid", bus.res_valid, 0);
            tick();
            chk("to_err_pulse", bus.err, 0);
            txn(4'b0100, 0, 0, 1'b0, 8'h33);
        end
`endif

        // Engine stalls 5 cycles, with a spurious result during ISSUE.
        for (int i = 0; i < 4; i++) smp[i] = 8'($urandom);
        txn(4'b1010, 5, 1, 1'b1, 8'hc3);

        // Randomized traffic.
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 4; i++) smp[i] = 8'($urandom);
            txn(4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 4),
                1'b0, 8'($urandom));
        end

        // Reset while waiting for the engine; the late result is then spurious.
        smp[1]       = 8'h77;
        bus.req      = 4'b0010;
        bus.req_data = {smp[3], smp[2], smp[1], smp[0]};
        tick();
        bus.eng_ready = 1'b1;
        tick();
        bus.eng_ready = 1'b0;
        bus.req       = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("wrst_busy", bus.busy, 0);
        chk("wrst_eng_valid", bus.eng_valid, 0);
        bus.eng_res_valid = 1'b1;
        bus.eng_res       = 8'h99;
        tick();
        bus.eng_res_valid = 1'b0;
        chk("wrst_res_valid", bus.res_valid, 0);
        chk("wrst_err", bus.err, 1);
        tick();
        chk("wrst_err_pulse", bus.err, 0);
        // Pointer and fill counters restarted: channel 0 first, channel 2 cold again.
        for (int i = 0; i < 4; i++) smp[i] = 8'($urandom);
        txn(4'b1111, 0, 1, 1'b0, 8'h01);
        txn(4'b0100, 0, 1, 1'b0, 8'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
